// File: rtl/l2_ring_responder_if.sv
// rtl/l2_ring_responder_if.sv - ring packet type and responder ring/L2 interface
package l2_ring_pkg;
    localparam logic [2:0] PKT_L2_READ      = 3'd0;
    localparam logic [2:0] PKT_L2_WRITE     = 3'd1;
    localparam logic [2:0] PKT_L2_WRITEBACK = 3'd2;

    typedef struct packed {
        logic        valid;
        logic        ack;
        logic [3:0]  dest_node;
        logic        cache_type;
        logic [2:0]  packet_type;
        logic [31:0] address;
        logic [31:0] data;
    } ring_packet_t;
endpackage

interface l2_ring_responder_if;
    l2_ring_pkg::ring_packet_t packet_in;
    l2_ring_pkg::ring_packet_t packet_out;
    logic                      l2_req_valid;
    l2_ring_pkg::ring_packet_t l2_req_packet;
    logic                      l2_req_ready;
    logic                      l2_resp_valid;
    l2_ring_pkg::ring_packet_t l2_resp_packet;
    logic                      l2_resp_ready;
    logic [31:0]               bounce_count;

    modport slave (
        input  packet_in, l2_req_ready, l2_resp_valid, l2_resp_packet,
        output packet_out, l2_req_valid, l2_req_packet, l2_resp_ready, bounce_count
    );

    modport master (
        output packet_in, l2_req_ready, l2_resp_valid, l2_resp_packet,
        input  packet_out, l2_req_valid, l2_req_packet, l2_resp_ready, bounce_count
    );
endinterface

// File: rtl/l2_ring_responder.sv
// rtl/l2_ring_responder.sv - memory-side ring endpoint: captures requests, inserts L2 responses
module l2_ring_responder #(
    parameter int REQ_FIFO_DEPTH  = 4,
    parameter int RESP_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    l2_ring_responder_if.slave   bus
);
    import l2_ring_pkg::*;

    localparam int RQ_AW = $clog2(REQ_FIFO_DEPTH);
    localparam int RQ_CW = RQ_AW + 1;
    localparam int RS_AW = $clog2(RESP_FIFO_DEPTH);
    localparam int RS_CW = RS_AW + 1;

    ring_packet_t             req_mem [REQ_FIFO_DEPTH];
    logic [RQ_AW-1:0]         req_wr_ptr, req_rd_ptr;
    logic [RQ_CW-1:0]         req_count;

    ring_packet_t             resp_mem [RESP_FIFO_DEPTH];
    logic [RS_AW-1:0]         resp_wr_ptr, resp_rd_ptr;
    logic [RS_CW-1:0]         resp_count;

    ring_packet_t             packet_out_q;
    ring_packet_t             next_packet;
    logic [31:0]              bounce_q;

    logic req_full, is_req, capture, bounce, req_deq;
    logic resp_full, resp_enq, slot_free, insert;

    // Full/empty decisions use start-of-cycle occupancy only.
    assign req_full  = (req_count == RQ_CW'(REQ_FIFO_DEPTH));
    assign is_req    = bus.packet_in.valid && !bus.packet_in.ack;
    assign capture   = is_req && !req_full;
    assign bounce    = is_req && req_full;
    assign req_deq   = (req_count != '0) && bus.l2_req_ready;

    assign resp_full = (resp_count == RS_CW'(RESP_FIFO_DEPTH));
    assign resp_enq  = bus.l2_resp_valid && !resp_full;
    assign slot_free = !bus.packet_in.valid || capture;
    assign insert    = slot_free && (resp_count != '0);

    assign bus.l2_req_valid  = (req_count != '0);
    assign bus.l2_req_packet = req_mem[req_rd_ptr];
    assign bus.l2_resp_ready = !resp_full;
    assign bus.packet_out    = packet_out_q;
    assign bus.bounce_count  = bounce_q;

    always_comb begin
        next_packet = bus.packet_in;
        if (capture) begin
            next_packet = '0;
        end
        if (insert) begin
            next_packet       = resp_mem[resp_rd_ptr];
            next_packet.valid = 1'b1;
            next_packet.ack   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            packet_out_q <= '0;
            bounce_q     <= '0;
            req_wr_ptr   <= '0;
            req_rd_ptr   <= '0;
            req_count    <= '0;
            resp_wr_ptr  <= '0;
            resp_rd_ptr  <= '0;
            resp_count   <= '0;
        end else begin
            packet_out_q <= next_packet;
            if (bounce && (bounce_q != 32'hFFFF_FFFF)) begin
                bounce_q <= bounce_q + 32'd1;
            end

            if (capture) req_wr_ptr <= req_wr_ptr + RQ_AW'(1);
            if (req_deq) req_rd_ptr <= req_rd_ptr + RQ_AW'(1);
            case ({capture, req_deq})
                2'b10:   req_count <= req_count + RQ_CW'(1);
                2'b01:   req_count <= req_count - RQ_CW'(1);
                default: req_count <= req_count;
            endcase

            if (resp_enq) resp_wr_ptr <= resp_wr_ptr + RS_AW'(1);
            if (insert)   resp_rd_ptr <= resp_rd_ptr + RS_AW'(1);
            case ({resp_enq, insert})
                2'b10:   resp_count <= resp_count + RS_CW'(1);
                2'b01:   resp_count <= resp_count - RS_CW'(1);
                default: resp_count <= resp_count;
            endcase
        end
    end

    // Storage needs no reset; occupancy counters define what is live.
    always_ff @(posedge clk) begin
        if (capture)  req_mem[req_wr_ptr]   <= bus.packet_in;
        if (resp_enq) resp_mem[resp_wr_ptr] <= bus.l2_resp_packet;
    end
endmodule

// File: tb/tb_l2_ring_responder.sv
// tb/tb_l2_ring_responder.sv - directed scoreboard bench for l2_ring_responder
module tb_l2_ring_responder;
    import l2_ring_pkg::*;

    logic clk;
    logic reset;
    int   nchecks;
    int   nerrors;

    l2_ring_responder_if bus();

    l2_ring_responder #(.REQ_FIFO_DEPTH(4), .RESP_FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ring_packet_t req_q[$];
    ring_packet_t resp_q[$];

    function automatic ring_packet_t mk(input logic v, input logic a, input logic [3:0] d,
                                        input logic [2:0] t, input logic [31:0] addr,
                                        input logic [31:0] data);
        ring_packet_t p;
        p.valid       = v;
        p.ack         = a;
        p.dest_node   = d;
        p.cache_type  = d[0];
        p.packet_type = t;
        p.address     = addr;
        p.data        = data;
        return p;
    endfunction

    function automatic ring_packet_t as_resp(input ring_packet_t p);
        ring_packet_t r;
        r       = p;
        r.valid = 1'b1;
        r.ack   = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pkt(input string tag, input ring_packet_t obs, input ring_packet_t exp);
        chk(tag, 96'(obs), 96'(exp));
    endtask

    ring_packet_t p, r, e;

    initial begin
        clk = 0;
        nchecks = 0;
        nerrors = 0;
        reset = 1;
        bus.packet_in      = '0;
        bus.l2_req_ready   = 0;
        bus.l2_resp_valid  = 0;
        bus.l2_resp_packet = '0;
        repeat (2) @(posedge clk);
        #3 reset = 0;

        chk_pkt("rst_packet_out", bus.packet_out, '0);
        chk("rst_req_valid", 96'(bus.l2_req_valid), 96'(1'b0));
        chk("rst_resp_ready", 96'(bus.l2_resp_ready), 96'(1'b1));
        chk("rst_bounce", 96'(bus.bounce_count), 96'(32'd0));
        tick();

        // Single request is captured and the slot is freed
        p = mk(1, 0, 4'd2, PKT_L2_READ, 32'h1000, 32'h0);
        bus.packet_in = p;
        req_q.push_back(p);
        tick();
        bus.packet_in = '0;
        chk("t1_req_valid", 96'(bus.l2_req_valid), 96'(1'b1));
        chk("t1_req_addr", 96'(bus.l2_req_packet.address), 96'(32'h1000));
        chk_pkt("t1_slot_freed", bus.packet_out, '0);
        bus.l2_req_ready = 1;
        e = req_q.pop_front();
        chk_pkt("t1_req_head", bus.l2_req_packet, e);
        tick();
        bus.l2_req_ready = 0;
        chk("t1_req_drained", 96'(bus.l2_req_valid), 96'(1'b0));

        // Fill request FIFO, bounce the fifth and a sixth that coincides with a dequeue
        for (int i = 0; i < 4; i++) begin
            p = mk(1, 0, 4'(i), (i == 3) ? PKT_L2_WRITEBACK : PKT_L2_WRITE,
                   32'h2000 + 32'(i) * 32'h40, 32'(i));
            bus.packet_in = p;
            req_q.push_back(p);
            tick();
            chk_pkt("t2_captured_slot", bus.packet_out, '0);
        end
        p = mk(1, 0, 4'd5, PKT_L2_READ, 32'h3000, 32'h55);
        bus.packet_in = p;
        tick();
        chk_pkt("t2_bounce_pass", bus.packet_out, p);
        chk("t2_bounce_cnt1", 96'(bus.bounce_count), 96'(32'd1));
        p = mk(1, 0, 4'd6, PKT_L2_READ, 32'h3040, 32'h66);
        bus.packet_in = p;
        bus.l2_req_ready = 1;
        e = req_q.pop_front();
        chk_pkt("t2_drain_head", bus.l2_req_packet, e);
        tick();
        chk_pkt("t2_no_same_cycle_room", bus.packet_out, p);
        chk("t2_bounce_cnt2", 96'(bus.bounce_count), 96'(32'd2));
        bus.packet_in = '0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_drain_valid", 96'(bus.l2_req_valid), 96'(1'b1));
            e = req_q.pop_front();
            chk_pkt("t2_drain_head", bus.l2_req_packet, e);
            tick();
        end
        bus.l2_req_ready = 0;
        chk("t2_empty", 96'(bus.l2_req_valid), 96'(1'b0));

        // Response insertion into empty slots
        r = mk(0, 0, 4'd1, PKT_L2_READ, 32'h1000, 32'hA5A5_A5A5);
        chk("t3_resp_ready", 96'(bus.l2_resp_ready), 96'(1'b1));
        bus.l2_resp_valid  = 1;
        bus.l2_resp_packet = r;
        resp_q.push_back(as_resp(r));
        tick();
        bus.l2_resp_valid = 0;
        chk_pkt("t3_not_yet", bus.packet_out, '0);
        chk("t3_resp_ready_after", 96'(bus.l2_resp_ready), 96'(1'b1));
        tick();
        e = resp_q.pop_front();
        chk_pkt("t3_inserted", bus.packet_out, e);
        chk("t3_dest", 96'(bus.packet_out.dest_node), 96'(4'd1));

        // Ack traffic blocks insertion; responses follow in order on empty slots
        for (int i = 0; i < 5; i++) begin
            p = mk(1, 1, 4'(i + 8), PKT_L2_WRITE, 32'h4000 + 32'(i), 32'hACC0 + 32'(i));
            bus.packet_in = p;
            if (i < 3) begin
                r = mk(0, 0, 4'(i + 1), PKT_L2_READ, 32'h5000 + 32'(i), 32'hB000 + 32'(i));
                bus.l2_resp_valid  = 1;
                bus.l2_resp_packet = r;
                resp_q.push_back(as_resp(r));
            end else begin
                bus.l2_resp_valid = 0;
            end
            tick();
            chk_pkt("t4_ack_pass", bus.packet_out, p);
        end
        bus.packet_in = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = resp_q.pop_front();
            chk_pkt("t4_resp_order", bus.packet_out, e);
        end
        tick();
        chk_pkt("t4_resp_empty", bus.packet_out, '0);

        // Capture and insert on the same slot
        p = mk(1, 1, 4'd3, PKT_L2_READ, 32'h6000, 32'h1);
        bus.packet_in = p;
        r = mk(0, 0, 4'd7, PKT_L2_READ, 32'h6100, 32'hC3C3_C3C3);
        bus.l2_resp_valid  = 1;
        bus.l2_resp_packet = r;
        resp_q.push_back(as_resp(r));
        tick();
        bus.l2_resp_valid = 0;
        chk_pkt("t5_ack_pass", bus.packet_out, p);
        p = mk(1, 0, 4'd4, PKT_L2_WRITEBACK, 32'h6200, 32'hDEAD);
        bus.packet_in = p;
        req_q.push_back(p);
        tick();
        bus.packet_in = '0;
        e = resp_q.pop_front();
        chk_pkt("t5_same_slot_resp", bus.packet_out, e);
        chk("t5_req_valid", 96'(bus.l2_req_valid), 96'(1'b1));
        e = req_q.pop_front();
        chk_pkt("t5_req_head", bus.l2_req_packet, e);
        bus.l2_req_ready = 1;
        tick();
        bus.l2_req_ready = 0;

        // Reset mid-operation: both FIFOs hold two entries, bounce_count at 7
        for (int i = 0; i < 4; i++) begin
            bus.packet_in = mk(1, 0, 4'(i), PKT_L2_READ, 32'h7000 + 32'(i), 32'h0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            bus.packet_in = mk(1, 0, 4'(i), PKT_L2_READ, 32'h7100 + 32'(i), 32'h0);
            bus.l2_resp_valid  = (i < 2);
            bus.l2_resp_packet = mk(0, 0, 4'(i), PKT_L2_READ, 32'h7200 + 32'(i), 32'hE0);
            tick();
        end
        bus.l2_resp_valid = 0;
        bus.packet_in = mk(1, 1, 4'd9, PKT_L2_READ, 32'h7300, 32'h0);
        bus.l2_req_ready = 1;
        repeat (2) tick();
        bus.l2_req_ready = 0;
        chk("t6_bounce7", 96'(bus.bounce_count), 96'(32'd7));
        chk("t6_req_pending", 96'(bus.l2_req_valid), 96'(1'b1));
        #2 reset = 1;
        #1;
        chk_pkt("t6_rst_packet_out", bus.packet_out, '0);
        chk("t6_rst_req_valid", 96'(bus.l2_req_valid), 96'(1'b0));
        chk("t6_rst_resp_ready", 96'(bus.l2_resp_ready), 96'(1'b1));
        chk("t6_rst_bounce", 96'(bus.bounce_count), 96'(32'd0));
        bus.packet_in = '0;
        @(negedge clk);
        reset = 0;
        repeat (2) begin
            tick();
            chk_pkt("t6_no_stale_resp", bus.packet_out, '0);
            chk("t6_no_stale_req", 96'(bus.l2_req_valid), 96'(1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
